ahb_lite_master: RTL and testbench

// - AHB-Lite initiator bridging the simple valid/ready request interface onto an AHB bus.
// - Mirror of the bridge's AHB slave side: accepts {rd0_wr1, addr, wr_data, size} requests, issues

---
 rtl/ahb_lite_master_pkg.sv | 35 +++
 rtl/ahb_lite_master_if.sv | 40 ++++
 rtl/ahb_lite_master.sv | 123 ++++++++++++
 tb/tb_ahb_lite_master.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and the error-recovery state type for the downstream bridge master.
package ahb_lite_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    typedef enum logic {
        NORMAL     = 1'b0,
        ERR_CANCEL = 1'b1
    } estate_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE    = 3'd0;
    localparam logic [2:0] HSIZE_HALF    = 3'd1;
    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HSIZE_DWORD   = 3'd3;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Largest legal HSIZE for a data bus of the given byte width.
    function automatic logic [2:0] hsize_max(input int unsigned data_bytes);
        case (data_bytes)
            1:       return HSIZE_BYTE;
            2:       return HSIZE_HALF;
            4:       return HSIZE_WORD;
            default: return HSIZE_DWORD;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// Request-side handshake plus AHB-Lite master bus signals, seen from the master and from the slave/requester.
interface ahb_lite_master_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  i_valid;
    logic                  i_rd0_wr1;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic [2:0]            i_size;
    logic                  o_ready;
    logic                  o_resp_valid;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_err;

    logic [1:0]            o_htrans;
    logic [ADDR_WIDTH-1:0] o_haddr;
    logic                  o_hwrite;
    logic [2:0]            o_hsize;
    logic [2:0]            o_hburst;
    logic [DATA_WIDTH-1:0] o_hwdata;
    logic                  i_hready;
    logic                  i_hresp;
    logic [DATA_WIDTH-1:0] i_hrdata;

    modport master (
        input  i_valid, i_rd0_wr1, i_addr, i_wr_data, i_size,
        output o_ready, o_resp_valid, o_rd_data, o_err,
        output o_htrans, o_haddr, o_hwrite, o_hsize, o_hburst, o_hwdata,
        input  i_hready, i_hresp, i_hrdata
    );

    modport slave (
        output i_valid, i_rd0_wr1, i_addr, i_wr_data, i_size,
        input  o_ready, o_resp_valid, o_rd_data, o_err,
        input  o_htrans, o_haddr, o_hwrite, o_hsize, o_hburst, o_hwdata,
        output i_hready, i_hresp, i_hrdata
    );

endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: turns valid/ready requests into pipelined SINGLE NONSEQ transfers, one response each,
// with a two-cycle ERROR recovery that cancels and later re-issues the pending address phase.
module ahb_lite_master
    import ahb_lite_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic               i_clk_ahb,
    input logic               i_rst_ahb,
    ahb_lite_master_if.master bus
);

    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam logic [2:0]  SIZE_MAX   = hsize_max(DATA_BYTES);

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            size;
        logic [DATA_WIDTH-1:0] wdata;
    } a_stage_t;

    typedef struct packed {
        logic                  vld;
        logic                  wr;
        logic [DATA_WIDTH-1:0] wdata;
    } d_stage_t;

    a_stage_t              a_q;
    d_stage_t              d_q;
    estate_t               estate_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  err_q;

    logic                  advance;
    logic                  retire;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] align_mask;

    // The pipeline only moves on a completed phase outside error recovery.
    assign advance = bus.i_hready && (estate_q == NORMAL);
    assign retire  = d_q.vld && bus.i_hready;
    assign accept  = bus.i_valid && bus.o_ready;

    assign bus.o_ready      = !a_q.vld || advance;
    assign bus.o_htrans     = (a_q.vld && estate_q == NORMAL) ? NONSEQ : IDLE;
    assign bus.o_haddr      = a_q.addr;
    assign bus.o_hwrite     = a_q.wr;
    assign bus.o_hsize      = a_q.size;
    assign bus.o_hburst     = HBURST_SINGLE;
    assign bus.o_hwdata     = d_q.wdata;
    assign bus.o_resp_valid = resp_valid_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_err        = err_q;

    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            a_q          <= '0;
            d_q          <= '0;
            estate_q     <= NORMAL;
            resp_valid_q <= 1'b0;
            rd_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= retire;
            rd_data_q    <= (retire && !d_q.wr) ? bus.i_hrdata : '0;
            err_q        <= retire && (bus.i_hresp == HRESP_ERROR);

            // First ERROR cycle cancels the pending address phase until the error completes.
            unique case (estate_q)
                NORMAL: begin
                    if (d_q.vld && bus.i_hresp == HRESP_ERROR && !bus.i_hready)
                        estate_q <= ERR_CANCEL;
                end
                ERR_CANCEL: begin
                    if (bus.i_hready)
                        estate_q <= NORMAL;
                end
                default: estate_q <= NORMAL;
            endcase

            if (advance) begin
                if (a_q.vld) begin
                    d_q.vld   <= 1'b1;
                    d_q.wr    <= a_q.wr;
                    d_q.wdata <= a_q.wdata;
                end else begin
                    d_q <= '0;
                end
            end else if (retire) begin
                d_q.vld <= 1'b0;
            end

            if (accept) begin
                a_q.vld   <= 1'b1;
                a_q.wr    <= bus.i_rd0_wr1;
                a_q.addr  <= bus.i_addr;
                a_q.size  <= bus.i_size;
                a_q.wdata <= bus.i_rd0_wr1 ? bus.i_wr_data : '0;
            end else if (advance) begin
                a_q.vld <= 1'b0;
            end
        end
    end

    assign align_mask = ~({ADDR_WIDTH{1'b1}} << bus.i_size);

    a_size_legal: assert property (@(posedge i_clk_ahb) disable iff (i_rst_ahb)
        accept |-> (bus.i_size <= SIZE_MAX))
        else $error("ahb_lite_master: request size wider than data bus");

    a_addr_aligned: assert property (@(posedge i_clk_ahb) disable iff (i_rst_ahb)
        accept |-> ((bus.i_addr & align_mask) == '0))
        else $error("ahb_lite_master: request address not aligned to size");

    a_one_cycle_error: assert property (@(posedge i_clk_ahb) disable iff (i_rst_ahb)
        !(estate_q == NORMAL && d_q.vld && bus.i_hready && bus.i_hresp != HRESP_OKAY))
        else $error("ahb_lite_master: slave gave single-cycle ERROR response");

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench: directed scenarios plus a randomized run against a transaction-level slave/scoreboard.
module tb_ahb_lite_master;
    import ahb_lite_master_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ahb_lite_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    ahb_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk_ahb (clk),
        .i_rst_ahb (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    function automatic logic [31:0] slv_rdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic slv_err(input logic [31:0] a);
        return (a[9:4] % 6'd5) == 6'd0;
    endfunction

    task automatic set_req(input logic v, input logic wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] d);
        bus.i_valid   = v;
        bus.i_rd0_wr1 = wr;
        bus.i_addr    = a;
        bus.i_size    = sz;
        bus.i_wr_data = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite, bus.o_hsize, bus.o_hburst} !== 41'd0) begin
            errors++;
            $display("FAIL reset_addr_phase: got %h exp 0",
                     {bus.o_htrans, bus.o_haddr, bus.o_hwrite, bus.o_hsize, bus.o_hburst});
        end
        checks++;
        if ({bus.o_hwdata, bus.o_rd_data, bus.o_resp_valid, bus.o_err} !== 66'd0) begin
            errors++;
            $display("FAIL reset_data: hwdata %h rd %h rv %b err %b exp all 0",
                     bus.o_hwdata, bus.o_rd_data, bus.o_resp_valid, bus.o_err);
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 1", bus.o_ready);
        end
    endtask

    task automatic test_write;
        @(negedge clk);
        set_req(1'b1, 1'b1, 32'h1000, HSIZE_WORD, 32'hDEAD_BEEF);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite, bus.o_hsize} !== {NONSEQ, 32'h1000, 1'b1, HSIZE_WORD}) begin
            errors++;
            $display("FAIL write_addr: htrans %b haddr %h hwrite %b hsize %0d exp 10/1000/1/2",
                     bus.o_htrans, bus.o_haddr, bus.o_hwrite, bus.o_hsize);
        end
        @(negedge clk);
        checks++;
        if (bus.o_hwdata !== 32'hDEAD_BEEF || bus.o_htrans !== IDLE) begin
            errors++;
            $display("FAIL write_data: hwdata %h htrans %b exp deadbeef/00", bus.o_hwdata, bus.o_htrans);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_err, bus.o_rd_data} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL write_resp: rv %b err %b rd %h exp 1/0/0", bus.o_resp_valid, bus.o_err, bus.o_rd_data);
        end
        @(negedge clk);
        checks++;
        if (bus.o_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_resp_pulse: rv %b exp 0", bus.o_resp_valid);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite} !== {NONSEQ, 32'h20, 1'b0}) begin
            errors++;
            $display("FAIL b2b_addr0: htrans %b haddr %h hwrite %b exp 10/20/0", bus.o_htrans, bus.o_haddr, bus.o_hwrite);
        end
        set_req(1'b1, 1'b0, 32'h24, HSIZE_WORD, 32'h0);
        @(negedge clk);
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite} !== {NONSEQ, 32'h24, 1'b0}) begin
            errors++;
            $display("FAIL b2b_addr1: htrans %b haddr %h hwrite %b exp 10/24/0", bus.o_htrans, bus.o_haddr, bus.o_hwrite);
        end
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        bus.i_hrdata = 32'h1111_1111;
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_err, bus.o_rd_data} !== {1'b1, 1'b0, 32'h1111_1111}) begin
            errors++;
            $display("FAIL b2b_resp0: rv %b err %b rd %h exp 1/0/11111111", bus.o_resp_valid, bus.o_err, bus.o_rd_data);
        end
        bus.i_hrdata = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_err, bus.o_rd_data} !== {1'b1, 1'b0, 32'h2222_2222}) begin
            errors++;
            $display("FAIL b2b_resp1: rv %b err %b rd %h exp 1/0/22222222", bus.o_resp_valid, bus.o_err, bus.o_rd_data);
        end
        bus.i_hrdata = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_wait_states;
        @(negedge clk);
        set_req(1'b1, 1'b1, 32'h40, HSIZE_WORD, 32'hA5A5_0F0F);
        @(negedge clk);
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite} !== {NONSEQ, 32'h40, 1'b1}) begin
            errors++;
            $display("FAIL wait_addr_wr: htrans %b haddr %h hwrite %b exp 10/40/1", bus.o_htrans, bus.o_haddr, bus.o_hwrite);
        end
        set_req(1'b1, 1'b0, 32'h44, HSIZE_WORD, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            bus.i_hready = 1'b0;
            #1;
            checks++;
            if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite, bus.o_hwdata, bus.o_ready, bus.o_resp_valid}
                !== {NONSEQ, 32'h44, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL wait_hold[%0d]: htrans %b haddr %h hwrite %b hwdata %h ready %b rv %b exp 10/44/0/a5a50f0f/0/0",
                         i, bus.o_htrans, bus.o_haddr, bus.o_hwrite, bus.o_hwdata, bus.o_ready, bus.o_resp_valid);
            end
            @(negedge clk);
        end
        bus.i_hready = 1'b1;
        bus.i_hrdata = 32'h3333_3333;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready_release: got %b exp 1", bus.o_ready);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_err, bus.o_rd_data, bus.o_htrans} !== {1'b1, 1'b0, 32'h0, IDLE}) begin
            errors++;
            $display("FAIL wait_resp_wr: rv %b err %b rd %h htrans %b exp 1/0/0/00",
                     bus.o_resp_valid, bus.o_err, bus.o_rd_data, bus.o_htrans);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_err, bus.o_rd_data} !== {1'b1, 1'b0, 32'h3333_3333}) begin
            errors++;
            $display("FAIL wait_resp_rd: rv %b err %b rd %h exp 1/0/33333333", bus.o_resp_valid, bus.o_err, bus.o_rd_data);
        end
        bus.i_hrdata = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_error;
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'h80, HSIZE_WORD, 32'h0);
        @(negedge clk);
        set_req(1'b1, 1'b1, 32'h84, HSIZE_WORD, 32'hCAFE_F00D);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        bus.i_hready = 1'b0;
        bus.i_hresp  = 1'b1;
        #1;
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_ready} !== {NONSEQ, 32'h84, 1'b0}) begin
            errors++;
            $display("FAIL err_first: htrans %b haddr %h ready %b exp 10/84/0", bus.o_htrans, bus.o_haddr, bus.o_ready);
        end
        @(negedge clk);
        bus.i_hready = 1'b1;
        #1;
        checks++;
        if ({bus.o_htrans, bus.o_ready, bus.o_resp_valid} !== {IDLE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL err_cancel: htrans %b ready %b rv %b exp 00/0/0", bus.o_htrans, bus.o_ready, bus.o_resp_valid);
        end
        @(negedge clk);
        bus.i_hresp = 1'b0;
        checks++;
        if ({bus.o_resp_valid, bus.o_err, bus.o_rd_data} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL err_resp: rv %b err %b rd %h exp 1/1/0", bus.o_resp_valid, bus.o_err, bus.o_rd_data);
        end
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_hwrite} !== {NONSEQ, 32'h84, 1'b1}) begin
            errors++;
            $display("FAIL err_reissue: htrans %b haddr %h hwrite %b exp 10/84/1", bus.o_htrans, bus.o_haddr, bus.o_hwrite);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_hwdata, bus.o_resp_valid, bus.o_htrans} !== {32'hCAFE_F00D, 1'b0, IDLE}) begin
            errors++;
            $display("FAIL err_wr_data: hwdata %h rv %b htrans %b exp cafef00d/0/00", bus.o_hwdata, bus.o_resp_valid, bus.o_htrans);
        end
        @(negedge clk);
        checks++;
        if ({bus.o_resp_valid, bus.o_err} !== 2'b10) begin
            errors++;
            $display("FAIL err_wr_resp: rv %b err %b exp 1/0", bus.o_resp_valid, bus.o_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_req(1'b1, 1'b0, 32'h100, HSIZE_WORD, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        @(negedge clk);
        bus.i_hready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_hready = 1'b1;
        #1;
        checks++;
        if ({bus.o_htrans, bus.o_haddr, bus.o_resp_valid, bus.o_ready} !== {IDLE, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_state: htrans %b haddr %h rv %b ready %b exp 00/0/0/1",
                     bus.o_htrans, bus.o_haddr, bus.o_resp_valid, bus.o_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.o_resp_valid, bus.o_htrans} !== {1'b0, IDLE}) begin
                errors++;
                $display("FAIL rstmid_quiet[%0d]: rv %b htrans %b exp 0/00", i, bus.o_resp_valid, bus.o_htrans);
            end
        end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.o_htrans, bus.o_resp_valid, bus.o_ready} !== {IDLE, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL idle[%0d]: htrans %b rv %b ready %b exp 00/0/1", i, bus.o_htrans, bus.o_resp_valid, bus.o_ready);
            end
        end
    endtask

    // Random requester + AHB slave with wait states and two-cycle ERRORs; checks ordering and responses.
    task automatic test_random;
        req_t        issued[$];
        rsp_t        rsp_q[$];
        req_t        cur, dp, exp_req;
        rsp_t        exp_rsp;
        logic        pend, dp_act, dp_err, rsp_due, accepted;
        logic [31:0] m;
        int          dp_wait, err_ph, cyc, n_acc, n_ret;
        pend = 1'b0; dp_act = 1'b0; dp_err = 1'b0; rsp_due = 1'b0;
        dp_wait = 0; err_ph = 0; cyc = 0; n_acc = 0; n_ret = 0;
        cur = '0; dp = '0;
        while (cyc < 3000 && !(cyc >= 600 && !pend && !dp_act && !rsp_due && issued.size() == 0)) begin
            @(negedge clk);
            checks++;
            if (bus.o_resp_valid !== rsp_due) begin
                errors++;
                $display("FAIL rnd_resp_timing cyc %0d: rv %b exp %b", cyc, bus.o_resp_valid, rsp_due);
            end else if (rsp_due) begin
                exp_rsp = rsp_q.pop_front();
                n_ret++;
                checks++;
                if ({bus.o_rd_data, bus.o_err} !== {exp_rsp.rdata, exp_rsp.err}) begin
                    errors++;
                    $display("FAIL rnd_resp cyc %0d: rd %h err %b exp %h/%b", cyc, bus.o_rd_data, bus.o_err, exp_rsp.rdata, exp_rsp.err);
                end
            end
            rsp_due = 1'b0;
            if (dp_act && err_ph == 1) begin
                checks++;
                if (bus.o_htrans !== IDLE) begin
                    errors++;
                    $display("FAIL rnd_err_cancel cyc %0d: htrans %b exp 00", cyc, bus.o_htrans);
                end
            end
            if (dp_act && dp_wait > 0)       {bus.i_hready, bus.i_hresp} = 2'b00;
            else if (dp_act && dp_err && err_ph == 0) {bus.i_hready, bus.i_hresp} = 2'b01;
            else if (dp_act && dp_err)        {bus.i_hready, bus.i_hresp} = 2'b11;
            else                              {bus.i_hready, bus.i_hresp} = 2'b10;
            bus.i_hrdata = (dp_act && !dp.wr) ? slv_rdata(dp.addr) : $urandom;
            if (!pend && cyc < 600 && $urandom_range(0, 9) < 7) begin
                cur.wr    = 1'($urandom_range(0, 1));
                cur.size  = 3'($urandom_range(0, 2));
                m         = (32'd1 << cur.size) - 32'd1;
                cur.addr  = $urandom & ~m;
                cur.wdata = $urandom;
                pend      = 1'b1;
            end
            set_req(pend, cur.wr, cur.addr, cur.size, cur.wdata);
            #1;
            accepted = pend && bus.o_ready;
            if (bus.i_hready) begin
                if (dp_act) begin
                    if (dp.wr) begin
                        checks++;
                        if (bus.o_hwdata !== dp.wdata) begin
                            errors++;
                            $display("FAIL rnd_hwdata cyc %0d: got %h exp %h", cyc, bus.o_hwdata, dp.wdata);
                        end
                    end
                    rsp_q.push_back(rsp_t'{rdata: dp.wr ? 32'h0 : slv_rdata(dp.addr), err: dp_err});
                    rsp_due = 1'b1;
                end
                dp_act = 1'b0;
                if (bus.o_htrans === NONSEQ) begin
                    checks++;
                    if (issued.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_spurious cyc %0d: NONSEQ haddr %h with nothing outstanding", cyc, bus.o_haddr);
                    end else begin
                        exp_req = issued.pop_front();
                        if ({bus.o_haddr, bus.o_hwrite, bus.o_hsize} !== {exp_req.addr, exp_req.wr, exp_req.size}) begin
                            errors++;
                            $display("FAIL rnd_addr cyc %0d: haddr %h hwrite %b hsize %0d exp %h/%b/%0d", cyc,
                                     bus.o_haddr, bus.o_hwrite, bus.o_hsize, exp_req.addr, exp_req.wr, exp_req.size);
                        end
                        dp      = exp_req;
                        dp_act  = 1'b1;
                        dp_err  = slv_err(exp_req.addr);
                        dp_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                        err_ph  = 0;
                    end
                end
            end else if (dp_wait > 0) begin
                dp_wait--;
            end else if (dp_err) begin
                err_ph = 1;
            end
            if (accepted) begin
                issued.push_back(cur);
                pend = 1'b0;
                n_acc++;
            end
            cyc++;
        end
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        {bus.i_hready, bus.i_hresp} = 2'b10;
        bus.i_hrdata = 32'h0;
        checks++;
        if (pend || dp_act || issued.size() != 0 || n_acc != n_ret || n_acc == 0) begin
            errors++;
            $display("FAIL rnd_drain: accepted %0d retired %0d outstanding %0d exp equal and nonzero",
                     n_acc, n_ret, issued.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
        bus.i_hready = 1'b1;
        bus.i_hresp  = 1'b0;
        bus.i_hrdata = 32'h0;
        test_reset();
        test_write();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_mid();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
